// File: rtl/xyz_drv_pkg.sv
// Shared definitions for the XYZ lane driver.
//   NLANE      : number of XYZ lanes driven
//   LANE_W     : width of a lane index (covers the illegal index 3)
//   lane_state_t : per-lane sequencing state
//   tmo_cnt_w  : width of a timeout counter able to hold 0..TIMEOUT
//   lane_next  : round-robin successor of a lane index
package xyz_drv_pkg;

  localparam int unsigned NLANE  = 3;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RES   = 3'd2,
    CHECK = 3'd3,
    RESP  = 3'd4
  } lane_state_t;

  // A disabled timeout (0) still gets a 1-bit counter so the vector is legal.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic logic [LANE_W-1:0] lane_next(input logic [LANE_W-1:0] l);
    return (l == LANE_W'(NLANE - 1)) ? '0 : l + LANE_W'(1);
  endfunction

endpackage

// File: rtl/xyz_lane_fsm.sv
// One XYZ lane: sequences start -> result -> check -> response for a single
// outstanding job, latching the operands and capturing result/check values.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   accept            : command handshake addressed to this lane
//   a, b, c, d        : command operands
//   rsp_done          : this lane's response was consumed
//   state             : registered lane state
//   start_a/b, result_c, check_d : operand outputs (0 while IDLE)
//   en_start/rdy_start, result_val/rdy_result, en_check/check_val/rdy_check : XYZ methods
//   res, chk, timeout : captured response payload
module xyz_lane_fsm
  import xyz_drv_pkg::*;
#(
  parameter int unsigned W       = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic        rsp_done,
  output lane_state_t state,
  output logic [W-1:0] start_a,
  output logic [W-1:0] start_b,
  output logic [W-1:0] result_c,
  output logic [W-1:0] check_d,
  output logic        en_start,
  input  logic        rdy_start,
  input  logic [W-1:0] result_val,
  input  logic        rdy_result,
  output logic        en_check,
  input  logic [W-1:0] check_val,
  input  logic        rdy_check,
  output logic [W-1:0] res,
  output logic [W-1:0] chk,
  output logic        timeout
);

  localparam int unsigned CW = tmo_cnt_w(TIMEOUT);

  lane_state_t   state_q;
  logic [W-1:0]  a_q, b_q, c_q, d_q;
  logic [W-1:0]  res_q, chk_q;
  logic          tmo_q;
  logic [CW-1:0] cnt_q;
  logic          tmo_hit;
  logic          busy;

  // The lane gives up on the TIMEOUT-th consecutive cycle of a low RDY.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Lane sequencing, operand latches, capture registers and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      chk_q   <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            d_q     <= d;
            // Clear the payload so an aborted job reports 0 for uncaptured values.
            res_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (rdy_start) begin
            cnt_q   <= '0;
            state_q <= RES;
          end else if (tmo_hit) begin
            cnt_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RES: begin
          if (rdy_result) begin
            res_q   <= result_val;
            cnt_q   <= '0;
            state_q <= CHECK;
          end else if (tmo_hit) begin
            cnt_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CHECK: begin
          if (rdy_check) begin
            chk_q   <= check_val;
            cnt_q   <= '0;
            state_q <= RESP;
          end else if (tmo_hit) begin
            cnt_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  assign start_a  = busy ? a_q : '0;
  assign start_b  = busy ? b_q : '0;
  assign result_c = busy ? c_q : '0;
  assign check_d  = busy ? d_q : '0;

  // Enables follow RDY directly and are suppressed while reset is asserted.
  assign en_start = !rst && (state_q == START) && rdy_start;
  assign en_check = !rst && (state_q == CHECK) && rdy_check;

  assign state   = state_q;
  assign res     = res_q;
  assign chk     = chk_q;
  assign timeout = tmo_q;

endmodule

// File: rtl/xyz_lane_driver.sv
// Initiator for the three-lane XYZ method interface. Accepts jobs on a
// valid/ready command port, runs each on its addressed lane and returns the
// captured result/check pair through a round-robin response port.
// Ports:
//   CLK, RST                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_lane   : command handshake and target lane (3 is illegal)
//   cmd_a..cmd_d                   : operands for start(a,b), result(c), check(d)
//   rsp_valid/rsp_ready/rsp_lane   : response handshake and originating lane
//   rsp_res, rsp_chk, rsp_timeout  : response payload
//   bad_lane                       : sticky flag for a consumed lane-3 command
//   XYZ_i_* / EN_XYZ_i_* / RDY_XYZ_i_* : lane i method signals, i = 0..2
module xyz_lane_driver
  import xyz_drv_pkg::*;
#(
  parameter int unsigned W       = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LANE_W-1:0] cmd_lane,
  input  logic [W-1:0]      cmd_a,
  input  logic [W-1:0]      cmd_b,
  input  logic [W-1:0]      cmd_c,
  input  logic [W-1:0]      cmd_d,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LANE_W-1:0] rsp_lane,
  output logic [W-1:0]      rsp_res,
  output logic [W-1:0]      rsp_chk,
  output logic              rsp_timeout,
  output logic              bad_lane,
  output logic [W-1:0]      XYZ_0_start_a,
  output logic [W-1:0]      XYZ_0_start_b,
  output logic              EN_XYZ_0_start,
  input  logic              RDY_XYZ_0_start,
  output logic [W-1:0]      XYZ_0_result_c,
  input  logic [W-1:0]      XYZ_0_result,
  input  logic              RDY_XYZ_0_result,
  output logic [W-1:0]      XYZ_0_check_d,
  output logic              EN_XYZ_0_check,
  input  logic [W-1:0]      XYZ_0_check,
  input  logic              RDY_XYZ_0_check,
  output logic [W-1:0]      XYZ_1_start_a,
  output logic [W-1:0]      XYZ_1_start_b,
  output logic              EN_XYZ_1_start,
  input  logic              RDY_XYZ_1_start,
  output logic [W-1:0]      XYZ_1_result_c,
  input  logic [W-1:0]      XYZ_1_result,
  input  logic              RDY_XYZ_1_result,
  output logic [W-1:0]      XYZ_1_check_d,
  output logic              EN_XYZ_1_check,
  input  logic [W-1:0]      XYZ_1_check,
  input  logic              RDY_XYZ_1_check,
  output logic [W-1:0]      XYZ_2_start_a,
  output logic [W-1:0]      XYZ_2_start_b,
  output logic              EN_XYZ_2_start,
  input  logic              RDY_XYZ_2_start,
  output logic [W-1:0]      XYZ_2_result_c,
  input  logic [W-1:0]      XYZ_2_result,
  input  logic              RDY_XYZ_2_result,
  output logic [W-1:0]      XYZ_2_check_d,
  output logic              EN_XYZ_2_check,
  input  logic [W-1:0]      XYZ_2_check,
  input  logic              RDY_XYZ_2_check
);

  lane_state_t       st [NLANE];
  logic [W-1:0]      res_a [NLANE];
  logic [W-1:0]      chk_a [NLANE];
  logic [NLANE-1:0]  tmo_v;
  logic [NLANE-1:0]  idle, in_resp, accept, done;

  logic              lane_free;
  logic              cmd_fire, bad_fire, rsp_fire;
  logic [LANE_W-1:0] rr_q, rr_pick, rr_idx, grant;
  logic              rr_found;
  logic              lock_q;
  logic [LANE_W-1:0] lock_lane_q;
  logic              bad_lane_q;

  // Per-lane status decode from the registered lane states.
  always_comb begin
    idle    = '0;
    in_resp = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      idle[i]    = (st[i] == IDLE);
      in_resp[i] = (st[i] == RESP);
    end
  end

  // Command port: lane 3 is always consumed so a bad command cannot block.
  always_comb begin
    lane_free = 1'b0;
    case (cmd_lane)
      2'd0:    lane_free = idle[0];
      2'd1:    lane_free = idle[1];
      2'd2:    lane_free = idle[2];
      default: lane_free = 1'b1;
    endcase
  end

  assign cmd_ready = !RST && lane_free;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign bad_fire  = cmd_fire && (cmd_lane == LANE_W'(NLANE));

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      accept[i] = cmd_fire && (cmd_lane == LANE_W'(i));
    end
  end

  // Round-robin search over lanes in RESP, starting at the pointer.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_q;
    rr_idx   = rr_q;
    for (int unsigned k = 0; k < NLANE; k++) begin
      if (!rr_found && in_resp[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
      rr_idx = lane_next(rr_idx);
    end
  end

  // A stalled response keeps its grant even if a higher-priority lane arrives.
  assign grant     = lock_q ? lock_lane_q : rr_pick;
  assign rsp_valid = !RST && (lock_q || rr_found);
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    done = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      done[i] = rsp_fire && (grant == LANE_W'(i));
    end
  end

  // Response payload mux.
  always_comb begin
    rsp_res     = '0;
    rsp_chk     = '0;
    rsp_timeout = 1'b0;
    if (rsp_valid) begin
      case (grant)
        2'd0: begin rsp_res = res_a[0]; rsp_chk = chk_a[0]; rsp_timeout = tmo_v[0]; end
        2'd1: begin rsp_res = res_a[1]; rsp_chk = chk_a[1]; rsp_timeout = tmo_v[1]; end
        2'd2: begin rsp_res = res_a[2]; rsp_chk = chk_a[2]; rsp_timeout = tmo_v[2]; end
        default: ;
      endcase
    end
  end

  assign rsp_lane = rsp_valid ? grant : '0;

  // Arbiter pointer, grant lock and sticky bad-lane flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_lane_q <= '0;
      bad_lane_q  <= 1'b0;
    end else begin
      if (rsp_fire) begin
        rr_q   <= lane_next(grant);
        lock_q <= 1'b0;
      end else if (rsp_valid) begin
        lock_q      <= 1'b1;
        lock_lane_q <= grant;
      end
      if (bad_fire) begin
        bad_lane_q <= 1'b1;
      end
    end
  end

  assign bad_lane = bad_lane_q;

  xyz_lane_fsm #(.W(W), .TIMEOUT(TIMEOUT)) u_lane0 (
    .clk        (CLK),
    .rst        (RST),
    .accept     (accept[0]),
    .a          (cmd_a),
    .b          (cmd_b),
    .c          (cmd_c),
    .d          (cmd_d),
    .rsp_done   (done[0]),
    .state      (st[0]),
    .start_a    (XYZ_0_start_a),
    .start_b    (XYZ_0_start_b),
    .result_c   (XYZ_0_result_c),
    .check_d    (XYZ_0_check_d),
    .en_start   (EN_XYZ_0_start),
    .rdy_start  (RDY_XYZ_0_start),
    .result_val (XYZ_0_result),
    .rdy_result (RDY_XYZ_0_result),
    .en_check   (EN_XYZ_0_check),
    .check_val  (XYZ_0_check),
    .rdy_check  (RDY_XYZ_0_check),
    .res        (res_a[0]),
    .chk        (chk_a[0]),
    .timeout    (tmo_v[0])
  );

  xyz_lane_fsm #(.W(W), .TIMEOUT(TIMEOUT)) u_lane1 (
    .clk        (CLK),
    .rst        (RST),
    .accept     (accept[1]),
    .a          (cmd_a),
    .b          (cmd_b),
    .c          (cmd_c),
    .d          (cmd_d),
    .rsp_done   (done[1]),
    .state      (st[1]),
    .start_a    (XYZ_1_start_a),
    .start_b    (XYZ_1_start_b),
    .result_c   (XYZ_1_result_c),
    .check_d    (XYZ_1_check_d),
    .en_start   (EN_XYZ_1_start),
    .rdy_start  (RDY_XYZ_1_start),
    .result_val (XYZ_1_result),
    .rdy_result (RDY_XYZ_1_result),
    .en_check   (EN_XYZ_1_check),
    .check_val  (XYZ_1_check),
    .rdy_check  (RDY_XYZ_1_check),
    .res        (res_a[1]),
    .chk        (chk_a[1]),
    .timeout    (tmo_v[1])
  );

  xyz_lane_fsm #(.W(W), .TIMEOUT(TIMEOUT)) u_lane2 (
    .clk        (CLK),
    .rst        (RST),
    .accept     (accept[2]),
    .a          (cmd_a),
    .b          (cmd_b),
    .c          (cmd_c),
    .d          (cmd_d),
    .rsp_done   (done[2]),
    .state      (st[2]),
    .start_a    (XYZ_2_start_a),
    .start_b    (XYZ_2_start_b),
    .result_c   (XYZ_2_result_c),
    .check_d    (XYZ_2_check_d),
    .en_start   (EN_XYZ_2_start),
    .rdy_start  (RDY_XYZ_2_start),
    .result_val (XYZ_2_result),
    .rdy_result (RDY_XYZ_2_result),
    .en_check   (EN_XYZ_2_check),
    .check_val  (XYZ_2_check),
    .rdy_check  (RDY_XYZ_2_check),
    .res        (res_a[2]),
    .chk        (chk_a[2]),
    .timeout    (tmo_v[2])
  );

endmodule

// File: tb/tb_xyz_lane_driver.sv
// Directed testbench for xyz_lane_driver. A default instance (TIMEOUT=64)
// covers normal sequencing; a second instance with TIMEOUT=8 shares all
// inputs and is observed only for the timeout scenario.
module tb_xyz_lane_driver;

  localparam int unsigned W = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic         cmd_valid, rsp_ready;
  logic [1:0]   cmd_lane;
  logic [W-1:0] cmd_a, cmd_b, cmd_c, cmd_d;
  logic         RDY_XYZ_0_start, RDY_XYZ_0_result, RDY_XYZ_0_check;
  logic         RDY_XYZ_1_start, RDY_XYZ_1_result, RDY_XYZ_1_check;
  logic         RDY_XYZ_2_start, RDY_XYZ_2_result, RDY_XYZ_2_check;
  logic [W-1:0] XYZ_0_result, XYZ_0_check, XYZ_1_result, XYZ_1_check, XYZ_2_result, XYZ_2_check;

  logic         cmd_ready, rsp_valid, rsp_timeout, bad_lane;
  logic [1:0]   rsp_lane;
  logic [W-1:0] rsp_res, rsp_chk;
  logic [W-1:0] XYZ_0_start_a, XYZ_0_start_b, XYZ_0_result_c, XYZ_0_check_d;
  logic [W-1:0] XYZ_1_start_a, XYZ_1_start_b, XYZ_1_result_c, XYZ_1_check_d;
  logic [W-1:0] XYZ_2_start_a, XYZ_2_start_b, XYZ_2_result_c, XYZ_2_check_d;
  logic         EN_XYZ_0_start, EN_XYZ_0_check, EN_XYZ_1_start, EN_XYZ_1_check, EN_XYZ_2_start, EN_XYZ_2_check;

  logic         t8_cmd_ready, t8_rsp_valid, t8_rsp_timeout, t8_bad_lane;
  logic [1:0]   t8_rsp_lane;
  logic [W-1:0] t8_rsp_res, t8_rsp_chk;
  logic [W-1:0] t8_0_sa, t8_0_sb, t8_0_rc, t8_0_cd;
  logic [W-1:0] t8_1_sa, t8_1_sb, t8_1_rc, t8_1_cd;
  logic [W-1:0] t8_2_sa, t8_2_sb, t8_2_rc, t8_2_cd;
  logic         t8_0_es, t8_0_ec, t8_1_es, t8_1_ec, t8_2_es, t8_2_ec;

  int n_cmp;
  int n_bad;

  xyz_lane_driver dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
    .rsp_res(rsp_res), .rsp_chk(rsp_chk), .rsp_timeout(rsp_timeout), .bad_lane(bad_lane),
    .XYZ_0_start_a(XYZ_0_start_a), .XYZ_0_start_b(XYZ_0_start_b), .EN_XYZ_0_start(EN_XYZ_0_start),
    .RDY_XYZ_0_start(RDY_XYZ_0_start), .XYZ_0_result_c(XYZ_0_result_c), .XYZ_0_result(XYZ_0_result),
    .RDY_XYZ_0_result(RDY_XYZ_0_result), .XYZ_0_check_d(XYZ_0_check_d), .EN_XYZ_0_check(EN_XYZ_0_check),
    .XYZ_0_check(XYZ_0_check), .RDY_XYZ_0_check(RDY_XYZ_0_check),
    .XYZ_1_start_a(XYZ_1_start_a), .XYZ_1_start_b(XYZ_1_start_b), .EN_XYZ_1_start(EN_XYZ_1_start),
    .RDY_XYZ_1_start(RDY_XYZ_1_start), .XYZ_1_result_c(XYZ_1_result_c), .XYZ_1_result(XYZ_1_result),
    .RDY_XYZ_1_result(RDY_XYZ_1_result), .XYZ_1_check_d(XYZ_1_check_d), .EN_XYZ_1_check(EN_XYZ_1_check),
    .XYZ_1_check(XYZ_1_check), .RDY_XYZ_1_check(RDY_XYZ_1_check),
    .XYZ_2_start_a(XYZ_2_start_a), .XYZ_2_start_b(XYZ_2_start_b), .EN_XYZ_2_start(EN_XYZ_2_start),
    .RDY_XYZ_2_start(RDY_XYZ_2_start), .XYZ_2_result_c(XYZ_2_result_c), .XYZ_2_result(XYZ_2_result),
    .RDY_XYZ_2_result(RDY_XYZ_2_result), .XYZ_2_check_d(XYZ_2_check_d), .EN_XYZ_2_check(EN_XYZ_2_check),
    .XYZ_2_check(XYZ_2_check), .RDY_XYZ_2_check(RDY_XYZ_2_check)
  );

  xyz_lane_driver #(.W(W), .TIMEOUT(8)) dut_t8 (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(t8_cmd_ready), .cmd_lane(cmd_lane),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
    .rsp_valid(t8_rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(t8_rsp_lane),
    .rsp_res(t8_rsp_res), .rsp_chk(t8_rsp_chk), .rsp_timeout(t8_rsp_timeout), .bad_lane(t8_bad_lane),
    .XYZ_0_start_a(t8_0_sa), .XYZ_0_start_b(t8_0_sb), .EN_XYZ_0_start(t8_0_es),
    .RDY_XYZ_0_start(RDY_XYZ_0_start), .XYZ_0_result_c(t8_0_rc), .XYZ_0_result(XYZ_0_result),
    .RDY_XYZ_0_result(RDY_XYZ_0_result), .XYZ_0_check_d(t8_0_cd), .EN_XYZ_0_check(t8_0_ec),
    .XYZ_0_check(XYZ_0_check), .RDY_XYZ_0_check(RDY_XYZ_0_check),
    .XYZ_1_start_a(t8_1_sa), .XYZ_1_start_b(t8_1_sb), .EN_XYZ_1_start(t8_1_es),
    .RDY_XYZ_1_start(RDY_XYZ_1_start), .XYZ_1_result_c(t8_1_rc), .XYZ_1_result(XYZ_1_result),
    .RDY_XYZ_1_result(RDY_XYZ_1_result), .XYZ_1_check_d(t8_1_cd), .EN_XYZ_1_check(t8_1_ec),
    .XYZ_1_check(XYZ_1_check), .RDY_XYZ_1_check(RDY_XYZ_1_check),
    .XYZ_2_start_a(t8_2_sa), .XYZ_2_start_b(t8_2_sb), .EN_XYZ_2_start(t8_2_es),
    .RDY_XYZ_2_start(RDY_XYZ_2_start), .XYZ_2_result_c(t8_2_rc), .XYZ_2_result(XYZ_2_result),
    .RDY_XYZ_2_result(RDY_XYZ_2_result), .XYZ_2_check_d(t8_2_cd), .EN_XYZ_2_check(t8_2_ec),
    .XYZ_2_check(XYZ_2_check), .RDY_XYZ_2_check(RDY_XYZ_2_check)
  );

  function automatic logic any_en();
    return EN_XYZ_0_start | EN_XYZ_0_check | EN_XYZ_1_start |
           EN_XYZ_1_check | EN_XYZ_2_start | EN_XYZ_2_check;
  endfunction

  function automatic logic [W-1:0] ops_or();
    return XYZ_0_start_a | XYZ_0_start_b | XYZ_0_result_c | XYZ_0_check_d |
           XYZ_1_start_a | XYZ_1_start_b | XYZ_1_result_c | XYZ_1_check_d |
           XYZ_2_start_a | XYZ_2_start_b | XYZ_2_result_c | XYZ_2_check_d;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic all_rdy(input logic v);
    RDY_XYZ_0_start = v; RDY_XYZ_0_result = v; RDY_XYZ_0_check = v;
    RDY_XYZ_1_start = v; RDY_XYZ_1_result = v; RDY_XYZ_1_check = v;
    RDY_XYZ_2_start = v; RDY_XYZ_2_result = v; RDY_XYZ_2_check = v;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
  endtask

  // Offers a command until accepted; returns in the cycle after the handshake.
  task automatic send_cmd(input logic [1:0] lane, input logic [W-1:0] a, b, c, d);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1; cmd_lane = lane;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = cmd_ready;
      next_cycle();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL send_cmd lane %0d: accepted=%0b want 1", lane, ok);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (any_en() !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %0b want 0", any_en()); end
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    n_cmp++;
    if (bad_lane !== 1'b0) begin n_bad++; $display("FAIL rst_bad_lane: got %0b want 0", bad_lane); end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
    n_cmp++;
    if (ops_or() !== '0) begin n_bad++; $display("FAIL rst_operands: got %0h want 0", ops_or()); end
    next_cycle();
  endtask

  task automatic test_basic();
    XYZ_1_result = 5'd9; XYZ_1_check = 5'd17;
    send_cmd(2'd1, 5'd3, 5'd4, 5'd5, 5'd6);
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_1_start !== 1'b1 || XYZ_1_start_a !== 5'd3 || XYZ_1_start_b !== 5'd4)
      begin n_bad++; $display("FAIL basic_start: en=%0b a=%0d b=%0d want 1 3 4", EN_XYZ_1_start, XYZ_1_start_a, XYZ_1_start_b); end
    n_cmp++;
    if (XYZ_1_result_c !== 5'd5) begin n_bad++; $display("FAIL basic_result_c: got %0d want 5", XYZ_1_result_c); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_1_start !== 1'b0 || EN_XYZ_1_check !== 1'b0)
      begin n_bad++; $display("FAIL basic_cycle2_en: start=%0b check=%0b want 0 0", EN_XYZ_1_start, EN_XYZ_1_check); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_1_check !== 1'b1 || XYZ_1_check_d !== 5'd6 || rsp_valid !== 1'b0)
      begin n_bad++; $display("FAIL basic_check: en=%0b d=%0d rv=%0b want 1 6 0", EN_XYZ_1_check, XYZ_1_check_d, rsp_valid); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd1 || rsp_res !== 5'd9 || rsp_chk !== 5'd17 || rsp_timeout !== 1'b0)
      begin n_bad++; $display("FAIL basic_rsp: v=%0b lane=%0d res=%0d chk=%0d to=%0b want 1 1 9 17 0",
                              rsp_valid, rsp_lane, rsp_res, rsp_chk, rsp_timeout); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || EN_XYZ_1_check !== 1'b0 || XYZ_1_start_a !== 5'd0)
      begin n_bad++; $display("FAIL basic_done: rv=%0b en=%0b a=%0d want 0 0 0", rsp_valid, EN_XYZ_1_check, XYZ_1_start_a); end
    next_cycle();
  endtask

  task automatic test_start_stall();
    bit en_seen;
    en_seen = 0;
    XYZ_0_result = 5'd11; XYZ_0_check = 5'd22;
    RDY_XYZ_0_start = 1'b0;
    send_cmd(2'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (any_en()) en_seen = 1;
      next_cycle();
    end
    n_cmp++;
    if (en_seen !== 1'b0) begin n_bad++; $display("FAIL stall_no_en: seen=%0b want 0", en_seen); end
    RDY_XYZ_0_start = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_0_start !== 1'b1 || XYZ_0_start_a !== 5'd1)
      begin n_bad++; $display("FAIL stall_start: en=%0b a=%0d want 1 1", EN_XYZ_0_start, XYZ_0_start_a); end
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_0_check !== 1'b1 || XYZ_0_check_d !== 5'd4)
      begin n_bad++; $display("FAIL stall_check: en=%0b d=%0d want 1 4", EN_XYZ_0_check, XYZ_0_check_d); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd0 || rsp_res !== 5'd11 || rsp_chk !== 5'd22 || rsp_timeout !== 1'b0)
      begin n_bad++; $display("FAIL stall_rsp: v=%0b lane=%0d res=%0d chk=%0d to=%0b want 1 0 11 22 0",
                              rsp_valid, rsp_lane, rsp_res, rsp_chk, rsp_timeout); end
    next_cycle();
  endtask

  task automatic test_timeout();
    bit got, en_seen;
    int at;
    logic [1:0] lane_s;
    logic [W-1:0] res_s, chk_s;
    logic tmo_s;
    got = 0; en_seen = 0; at = -1;
    lane_s = '0; res_s = '0; chk_s = '0; tmo_s = 1'b0;
    pulse_reset();
    XYZ_2_result = 5'd13; XYZ_2_check = 5'd25;
    RDY_XYZ_2_check = 1'b0;
    send_cmd(2'd2, 5'd1, 5'd1, 5'd1, 5'd1);
    for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
      @(negedge CLK);
      if (t8_2_ec) en_seen = 1;
      if (t8_rsp_valid) begin
        got = 1; at = cyc;
        lane_s = t8_rsp_lane; res_s = t8_rsp_res; chk_s = t8_rsp_chk; tmo_s = t8_rsp_timeout;
      end
      next_cycle();
    end
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL tmo_rsp_seen: got %0b want 1", got); end
    // CHECK entered in cycle 3; eight low-RDY cycles (3..10) end in RESP at cycle 11.
    n_cmp++;
    if (at != 11) begin n_bad++; $display("FAIL tmo_latency: cycle %0d want 11", at); end
    n_cmp++;
    if (lane_s !== 2'd2 || tmo_s !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: lane=%0d to=%0b want 2 1", lane_s, tmo_s); end
    n_cmp++;
    if (res_s !== 5'd13 || chk_s !== 5'd0) begin n_bad++; $display("FAIL tmo_payload: res=%0d chk=%0d want 13 0", res_s, chk_s); end
    n_cmp++;
    if (en_seen !== 1'b0) begin n_bad++; $display("FAIL tmo_no_check_en: seen=%0b want 0", en_seen); end
    pulse_reset();
    RDY_XYZ_2_check = 1'b1;
  endtask

  task automatic test_back_to_back();
    XYZ_0_result = 5'd1; XYZ_0_check = 5'd2;
    XYZ_1_result = 5'd3; XYZ_1_check = 5'd4;
    XYZ_2_result = 5'd5; XYZ_2_check = 5'd6;
    rsp_ready = 1'b0;
    cmd_a = 5'd10; cmd_b = 5'd11; cmd_c = 5'd12; cmd_d = 5'd13;
    cmd_valid = 1'b1;
    for (int l = 0; l < 3; l++) begin
      cmd_lane = 2'(l);
      @(negedge CLK);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept lane %0d: got %0b want 1", l, cmd_ready); end
      next_cycle();
    end
    cmd_lane = 2'd0; cmd_a = 5'd7;
    for (int cyc = 3; cyc <= 8; cyc++) begin
      if (cyc == 8) rsp_ready = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_lane0_busy cyc %0d: got %0b want 0", cyc, cmd_ready); end
      if (cyc >= 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_lane !== 2'd0 || rsp_res !== 5'd1 || rsp_chk !== 5'd2)
          begin n_bad++; $display("FAIL b2b_hold0 cyc %0d: v=%0b lane=%0d res=%0d chk=%0d want 1 0 1 2",
                                  cyc, rsp_valid, rsp_lane, rsp_res, rsp_chk); end
      end
      next_cycle();
    end
    @(negedge CLK);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_lane0_free: got %0b want 1", cmd_ready); end
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd1 || rsp_res !== 5'd3 || rsp_chk !== 5'd4)
      begin n_bad++; $display("FAIL b2b_rsp1: v=%0b lane=%0d res=%0d chk=%0d want 1 1 3 4", rsp_valid, rsp_lane, rsp_res, rsp_chk); end
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd2 || rsp_res !== 5'd5 || rsp_chk !== 5'd6)
      begin n_bad++; $display("FAIL b2b_rsp2: v=%0b lane=%0d res=%0d chk=%0d want 1 2 5 6", rsp_valid, rsp_lane, rsp_res, rsp_chk); end
    n_cmp++;
    if (EN_XYZ_0_start !== 1'b1 || XYZ_0_start_a !== 5'd7)
      begin n_bad++; $display("FAIL b2b_reissue_start: en=%0b a=%0d want 1 7", EN_XYZ_0_start, XYZ_0_start_a); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %0b want 0", rsp_valid); end
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd0 || rsp_res !== 5'd1 || rsp_chk !== 5'd2)
      begin n_bad++; $display("FAIL b2b_rsp0_again: v=%0b lane=%0d res=%0d chk=%0d want 1 0 1 2", rsp_valid, rsp_lane, rsp_res, rsp_chk); end
    next_cycle();
  endtask

  task automatic test_bad_lane();
    cmd_valid = 1'b1; cmd_lane = 2'd3;
    cmd_a = 5'd1; cmd_b = 5'd1; cmd_c = 5'd1; cmd_d = 5'd1;
    @(negedge CLK);
    n_cmp++;
    if (cmd_ready !== 1'b1 || bad_lane !== 1'b0)
      begin n_bad++; $display("FAIL bad_accept: ready=%0b bad=%0b want 1 0", cmd_ready, bad_lane); end
    next_cycle();
    cmd_valid = 1'b0; cmd_lane = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bad_lane !== 1'b1 || any_en() !== 1'b0 || rsp_valid !== 1'b0)
        begin n_bad++; $display("FAIL bad_after %0d: bad=%0b en=%0b rv=%0b want 1 0 0", i, bad_lane, any_en(), rsp_valid); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    XYZ_1_result = 5'd21; XYZ_1_check = 5'd30;
    rsp_ready = 1'b1;
    RDY_XYZ_1_check = 1'b0;
    send_cmd(2'd1, 5'd1, 5'd2, 5'd3, 5'd4);
    next_cycle();
    next_cycle();
    next_cycle();
    RST = 1'b1;
    RDY_XYZ_1_check = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (EN_XYZ_1_check !== 1'b0 || rsp_valid !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_gate: en=%0b rv=%0b want 0 0", EN_XYZ_1_check, rsp_valid); end
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (ops_or() !== '0 || bad_lane !== 1'b0 || cmd_ready !== 1'b1 || rsp_lane !== 2'd0 || rsp_res !== 5'd0)
      begin n_bad++; $display("FAIL rstmid_clear: ops=%0h bad=%0b ready=%0b lane=%0d res=%0d want 0 0 1 0 0",
                              ops_or(), bad_lane, cmd_ready, rsp_lane, rsp_res); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (rsp_valid !== 1'b0 || any_en() !== 1'b0)
        begin n_bad++; $display("FAIL rstmid_quiet %0d: rv=%0b en=%0b want 0 0", i, rsp_valid, any_en()); end
      next_cycle();
    end
    send_cmd(2'd1, 5'd2, 5'd2, 5'd2, 5'd2);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_lane !== 2'd1 || rsp_res !== 5'd21 || rsp_chk !== 5'd30 || rsp_timeout !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_rsp: v=%0b lane=%0d res=%0d chk=%0d to=%0b want 1 1 21 30 0",
                              rsp_valid, rsp_lane, rsp_res, rsp_chk, rsp_timeout); end
    next_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1;
    cmd_valid = 1'b0; cmd_lane = 2'd0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_d = '0;
    rsp_ready = 1'b1;
    all_rdy(1'b1);
    XYZ_0_result = '0; XYZ_0_check = '0;
    XYZ_1_result = '0; XYZ_1_check = '0;
    XYZ_2_result = '0; XYZ_2_check = '0;
    test_reset();
    test_basic();
    test_start_stall();
    test_timeout();
    test_back_to_back();
    test_bad_lane();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xyz_lane_driver.md
Name: xyz_lane_driver

Overview:
Initiator side of the three-lane XYZ method interface: start(a,b) action, result(c) value, check(d) actionvalue, each with RDY/EN handshakes. It accepts jobs on a valid/ready command port and sequences start, result and check on the addressed lane, honouring RDY. It returns the captured result/check pair on a round-robin-arbitrated response port. It sits between a test sequencer or host and any module that exports XYZ_0..XYZ_2.

Parameters:
W, 5, operand/result width for a, b, c, d, result and check.
TIMEOUT, 64, max cycles a lane waits on any RDY before aborting; 0 disables the timeout.

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
cmd_lane  in  2  target lane 0..2; 3 is illegal
cmd_a, cmd_b, cmd_c, cmd_d  in  W each  operands for start(a,b), result(c), check(d)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_lane  out  2  lane of the response
rsp_res  out  W  captured result value
rsp_chk  out  W  captured check return value
rsp_timeout  out  1  job aborted on timeout
bad_lane  out  1  sticky; set when a lane-3 command is consumed
XYZ_i_start_a, XYZ_i_start_b  out  W  (i=0..2) start operands
EN_XYZ_i_start  out  1  start enable
RDY_XYZ_i_start  in  1  start ready
XYZ_i_result_c  out  W  result argument
XYZ_i_result  in  W  result value
RDY_XYZ_i_result  in  1  result valid
XYZ_i_check_d  out  W  check argument
EN_XYZ_i_check  out  1  check enable
XYZ_i_check  in  W  check return value
RDY_XYZ_i_check  in  1  check ready

Behaviour:
- Reset (RST high at edge): all lanes go to IDLE. Timeout counters, RR pointer, bad_lane, captured res/chk and latched operands are all cleared to 0.
- While RST is high, every EN_* output is forced to 0 combinationally. A job in flight is abandoned with no response.
- Per-lane FSM states:
  - IDLE: a command handshake on this lane moves the lane to START. Operands are latched.
  - START: EN_start = RDY_start. Firing moves to RES.
  - RES: when RDY_result is high, capture XYZ_i_result and move to CHECK.
  - CHECK: EN_check = RDY_check. Firing captures XYZ_i_check and moves to RESP.
  - RESP: hold until granted and rsp_ready is high, then return to IDLE.
- Operand outputs drive the latched a/b/c/d continuously while the lane is not IDLE, and 0 while IDLE.
- cmd_ready = (cmd_lane==3) OR (lane[cmd_lane] is IDLE).
  - A lane-3 command is consumed, dropped, and sets bad_lane.
- At most one command is accepted per cycle. Each lane holds at most one outstanding job; lanes run independently and concurrently.
- Minimum latency, command handshake at cycle 0 with all RDY high: EN_start in cycle 1, result captured in cycle 2, EN_check in cycle 3, rsp_valid in cycle 4.
- A lane entering RESP at edge N raises rsp_valid in cycle N, if granted.
- Timeout: the counter increments each cycle a lane is in START, RES or CHECK with that state's RDY low. It resets on every state advance.
  - On reaching TIMEOUT-1, the lane goes to RESP with rsp_timeout=1.
  - Values not yet captured are reported as 0.
  - No EN is asserted in the abort cycle.
- Response arbiter: round-robin over lanes in RESP, starting at the RR pointer.
  - A grant is held stable while rsp_valid && !rsp_ready; rsp_* must not change.
  - On handshake, the RR pointer moves to granted+1 (mod 3).
- Simultaneous events: a lane returning IDLE in cycle N may accept a new command in cycle N+1, not N. cmd_ready uses the registered state.

Decomposition:
- xyz_drv_pkg holds:
  - NLANE=3;
  - lane_state_t enum {IDLE, START, RES, CHECK, RESP};
  - LANE_W=2;
  - the timeout counter width function clog2(TIMEOUT+1).
- Sub-module xyz_lane_fsm (one lane: FSM, operand latches, capture registers, timeout counter) is instantiated three times. The top level holds command decode, the RR arbiter and bad_lane.

Test Plan:
- All RDY held 1. Command lane 1, a=3 b=4 c=5 d=6; DUT result=9, check=17. Expect: EN_XYZ_1_start pulses one cycle with start_a=3, start_b=4; EN_XYZ_1_check pulses one cycle with check_d=6; rsp_valid 4 cycles after the command handshake with rsp_lane=1, res=9, chk=17, timeout=0.
- RDY_XYZ_0_start low for 10 cycles, then high. Expect: no EN while low, EN_XYZ_0_start in the first high cycle, correct response afterwards.
- TIMEOUT=8, RDY_XYZ_2_check stuck low. Expect: response with rsp_lane=2, rsp_timeout=1, chk=0, res equal to the captured value; EN_XYZ_2_check never asserted.
- Commands to lanes 0, 1, 2 on consecutive cycles; rsp_ready held low until all three lanes are in RESP, then held high. Expect: responses in lane order 0, 1, 2, each stable while stalled. A second lane-0 command is refused (cmd_ready=0) until lane 0 returns IDLE.
- Lane-3 command. Expect: cmd_ready=1, bad_lane=1 from the next cycle on, no EN activity, no response.
- RST asserted for one cycle while lane 1 is in CHECK with RDY_check high. Expect: EN_XYZ_1_check=0 in the reset cycle, no response, all outputs 0, and normal operation on the next command.
